ysyx_23060278_mdu_seq: RTL and testbench
========================================

Name: ysyx_23060278_mdu_seq

Overview:
- Multi-cycle sequencer that executes unsigned MUL, MULHU, DIVU and REMU by iterating on the shared 32-bit ALU.
- Multiply is shift-add; divide is restoring.
- The ALU is shared with the integer pipeline, so every ALU use is gated by an external grant.
- Sits beside the execute stage. It takes one request at a time and returns one response, with valid/ready on both sides.

Parameters:
- DATA_W, 32, operand/result width; must equal ALU width.
- CNT_W, 5, iteration counter width; 2**CNT_W == DATA_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 MUL, 01 MULHU, 10 DIVU, 11 REMU
- req_a  in  DATA_W  multiplicand / dividend
- req_b  in  DATA_W  multiplier / divisor
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  DATA_W  result
- resp_dbz  out  1  divide by zero (DIVU/REMU with req_b==0)
- alu_req  out  1  ALU wanted this cycle
- alu_gnt  in  1  ALU granted this cycle
- alu_a  out  DATA_W  ALU operand a
- alu_b  out  DATA_W  ALU operand b
- alu_ctl  out  3  000 add, 001 sub; no other codes driven
- alu_result  in  DATA_W  ALU result (combinational)
- alu_cf  in  1  ALU carry out; after sub, 1 iff a >= b unsigned

Behaviour:
- One clock domain (clk). rst is asynchronous and active-high. Polarity and synchronicity are fixed.
- States: IDLE, BUSY, DONE.
- Reset (any time, including mid-operation):
  - State goes to IDLE; all work is discarded.
  - resp_valid=0, resp_data=0, resp_dbz=0, alu_req=0, alu_a=0, alu_b=0, alu_ctl=000.
  - req_ready=1 once rst deasserts.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, a, b.
  - Divide with b==0: go to DONE next cycle; resp_data = 0xFFFFFFFF for DIVU or a for REMU; resp_dbz=1.
  - Otherwise: init counter=0 and go to BUSY.
  - MUL init: hi=0, lo=b, mcand=a.
  - DIV init: R=0, Q=a, D=b.
- BUSY:
  - req_ready=0, alu_req=1.
  - An iteration executes only in a cycle with alu_gnt=1. With alu_gnt=0 all state holds and ALU outputs stay stable.
  - MUL step: alu_a=hi, alu_b=mcand, alu_ctl=000.
    - lo[0]=1: {hi,lo} <= {alu_cf, alu_result, lo[31:1]}.
    - lo[0]=0: {hi,lo} <= {1'b0, hi, lo[31:1]}.
  - DIV step:
    - Rs = {R[30:0], Q[31]}, msb = R[31].
    - alu_a=Rs, alu_b=D, alu_ctl=001.
    - If msb|alu_cf: R <= alu_result, Q <= {Q[30:0],1}.
    - Else: R <= Rs, Q <= {Q[30:0],0}.
  - Counter increments per executed iteration. The iteration with counter==DATA_W-1 moves to DONE.
  - Latency with continuous grant: request accepted at cycle 0, resp_valid first high at cycle 33. Each grant-low cycle adds exactly one cycle.
- DONE:
  - resp_valid=1; resp_data selected as MUL lo, MULHU hi, DIVU Q, REMU R. resp_dbz=0 for non-zero divides.
  - resp_data and resp_dbz hold stable until resp_ready.
  - On resp_valid&resp_ready, go to IDLE. A new request cannot be accepted in the same cycle, so there is one bubble minimum.
  - alu_req=0 in IDLE and DONE; ALU outputs are driven to 0 there.
- Widths: the counter wraps only through the state change, never arithmetically. The carry from hi+mcand is never lost (it shifts into hi[31]).

Test Plan:
- MUL 7*6, alu_gnt=1, resp_ready=1 -> resp_valid at cycle 33, resp_data=42, dbz=0.
- a=b=0xFFFFFFFF: MUL -> 0x00000001; MULHU -> 0xFFFFFFFE.
- DIVU/REMU:
  - 100/7 -> 14 / 2.
  - 0xFFFFFFFF/0x80000000 -> 1 / 0x7FFFFFFF (exercises msb path).
  - 5/9 -> 0 / 5.
- Divide by zero, a=0x1234: DIVU -> resp_valid at cycle 1, data 0xFFFFFFFF, dbz=1; REMU -> 0x1234, dbz=1; alu_req stays 0.
- DIVU 100/7 with alu_gnt low for 5 cycles mid-operation and resp_ready low for 3 cycles in DONE:
  - resp_valid at cycle 38.
  - data=14 held stable across the stall.
  - req_ready=0 until the handshake.
- rst pulsed at cycle 10 of a MUL -> all outputs return to reset values immediately. A subsequent MULHU 0x10000*0x10000 returns 0x00000001.

Source files
------------

// File: rtl/ysyx_23060278_mdu_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sequencer on a shared, grant-gated ALU.
// Multiply is shift-add. Divide is restoring. One request is in flight at a time.
// Ports:
//   clk, rst                          clock, async active-high reset
//   req_valid/req_ready/req_op/a/b    request handshake and operands
//   resp_valid/resp_ready/data/dbz    response handshake, result, divide-by-zero flag
//   alu_req/alu_gnt                   ALU arbitration
//   alu_a/alu_b/alu_ctl               ALU operands and function (000 add, 001 sub)
//   alu_result/alu_cf                 ALU result and carry (sub: 1 iff a >= b)
module ysyx_23060278_mdu_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_dbz,
    output logic              alu_req,
    input  logic              alu_gnt,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cf
);

    localparam logic [1:0]       OP_MUL   = 2'b00;
    localparam logic [1:0]       OP_MULHU = 2'b01;
    localparam logic [1:0]       OP_DIVU  = 2'b10;
    localparam logic [1:0]       OP_REMU  = 2'b11;
    localparam logic [2:0]       CTL_ADD  = 3'b000;
    localparam logic [2:0]       CTL_SUB  = 3'b001;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state;
    logic [1:0]        op;
    logic [DATA_W-1:0] acc;   // MUL: hi,  DIV: R
    logic [DATA_W-1:0] sh;    // MUL: lo,  DIV: Q
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] step_acc;
    logic [DATA_W-1:0] step_sh;
    logic [DATA_W-1:0] step_alu_a;
    logic [DATA_W-1:0] sel_data;

    // One iteration of the datapath, plus the ALU operand a the next iteration needs.
    always_comb begin
        rs         = {acc[DATA_W-2:0], sh[DATA_W-1]};
        step_acc   = acc;
        step_sh    = sh;
        step_alu_a = '0;
        if (op[1]) begin
            // Shifted-out R msb means Rs >= 2**DATA_W > D, so the subtract always applies.
            if (acc[DATA_W-1] | alu_cf) begin
                step_acc = alu_result;
                step_sh  = {sh[DATA_W-2:0], 1'b1};
            end else begin
                step_acc = rs;
                step_sh  = {sh[DATA_W-2:0], 1'b0};
            end
            step_alu_a = {step_acc[DATA_W-2:0], step_sh[DATA_W-1]};
        end else begin
            // Carry of hi+mcand re-enters as the new hi msb.
            if (sh[0]) begin
                step_acc = {alu_cf, alu_result[DATA_W-1:1]};
                step_sh  = {alu_result[0], sh[DATA_W-1:1]};
            end else begin
                step_acc = {1'b0, acc[DATA_W-1:1]};
                step_sh  = {acc[0], sh[DATA_W-1:1]};
            end
            step_alu_a = step_acc;
        end
        case (op)
            OP_MUL:   sel_data = step_sh;
            OP_MULHU: sel_data = step_acc;
            OP_DIVU:  sel_data = step_sh;
            default:  sel_data = step_acc;
        endcase
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op         <= OP_MUL;
            acc        <= '0;
            sh         <= '0;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_dbz   <= 1'b0;
            alu_req    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctl    <= CTL_ADD;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op        <= req_op;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        if (req_op[1] && (req_b == '0)) begin
                            state      <= S_DONE;
                            resp_valid <= 1'b1;
                            resp_dbz   <= 1'b1;
                            resp_data  <= (req_op == OP_DIVU) ? '1 : req_a;
                        end else if (req_op[1]) begin
                            state   <= S_BUSY;
                            acc     <= '0;
                            sh      <= req_a;
                            alu_req <= 1'b1;
                            alu_a   <= DATA_W'(req_a[DATA_W-1]);
                            alu_b   <= req_b;
                            alu_ctl <= CTL_SUB;
                        end else begin
                            state   <= S_BUSY;
                            acc     <= '0;
                            sh      <= req_b;
                            alu_req <= 1'b1;
                            alu_a   <= '0;
                            alu_b   <= req_a;
                            alu_ctl <= CTL_ADD;
                        end
                    end
                end
                S_BUSY: begin
                    if (alu_gnt) begin
                        acc <= step_acc;
                        sh  <= step_sh;
                        if (cnt == CNT_LAST) begin
                            state      <= S_DONE;
                            cnt        <= '0;
                            alu_req    <= 1'b0;
                            alu_a      <= '0;
                            alu_b      <= '0;
                            alu_ctl    <= CTL_ADD;
                            resp_valid <= 1'b1;
                            resp_data  <= sel_data;
                            resp_dbz   <= 1'b0;
                        end else begin
                            cnt   <= cnt + CNT_W'(1);
                            alu_a <= step_alu_a;
                        end
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_data  <= '0;
                        resp_dbz   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060278_mdu_seq.sv
// Bench for ysyx_23060278_mdu_seq: behavioural ALU, arithmetic result model,
// per-cycle output comparison and literal expectations per transaction.
module tb_ysyx_23060278_mdu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_dbz;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctl;
    logic [31:0] alu_result;
    logic        alu_cf;

    ysyx_23060278_mdu_seq dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_dbz   (resp_dbz),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctl    (alu_ctl),
        .alu_result (alu_result),
        .alu_cf     (alu_cf)
    );

    always #5 clk = ~clk;

    // Shared integer ALU: add, or subtract with carry = (a >= b).
    logic [32:0] alu_sum;
    always_comb begin
        if (alu_ctl == 3'b001) alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else                   alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_result = alu_sum[31:0];
    assign alu_cf     = alu_sum[32];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // {dbz, data} from plain arithmetic.
    function automatic logic [32:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            2'b00:   model = {1'b0, p[31:0]};
            2'b01:   model = {1'b0, p[63:32]};
            2'b10:   model = (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
            default: model = (b == 0) ? {1'b1, a} : {1'b0, a % b};
        endcase
    endfunction

    // Expected view of the current cycle, maintained by the driver.
    logic        chk_en = 1'b0;
    logic        exp_ready, exp_valid, exp_busy, exp_dbz;
    logic [31:0] exp_data, exp_b;
    logic [2:0]  exp_ctl;
    logic        stalled_prev = 1'b0;
    logic [31:0] prev_a, prev_b;

    // Per-cycle comparison of every output against the model view.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("resp_valid", 32'(resp_valid), 32'(exp_valid));
            check("alu_req", 32'(alu_req), 32'(exp_busy));
            check("resp_data", resp_data, exp_valid ? exp_data : 32'h0);
            check("resp_dbz", 32'(resp_dbz), 32'(exp_valid & exp_dbz));
            if (exp_busy) begin
                check("alu_ctl", 32'(alu_ctl), 32'(exp_ctl));
                check("alu_b", alu_b, exp_b);
                if (stalled_prev) begin
                    check("alu_a_hold", alu_a, prev_a);
                    check("alu_b_hold", alu_b, prev_b);
                end
            end else begin
                check("alu_a_idle", alu_a, 32'h0);
                check("alu_b_idle", alu_b, 32'h0);
                check("alu_ctl_idle", 32'(alu_ctl), 32'h0);
            end
            stalled_prev = exp_busy && !alu_gnt;
            prev_a       = alu_a;
            prev_b       = alu_b;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic set_idle_exp();
        exp_ready = 1'b1;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_dbz   = 1'b0;
        exp_data  = 32'h0;
    endtask

    // One transaction: grant dropped for gs_len cycles from cycle gs_at,
    // resp_ready held low for rs_len cycles once the result is up.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int gs_at, input int gs_len, input int rs_len,
                          input int lit_lat, input logic [31:0] lit_data, input logic lit_dbz);
        logic [32:0] m;
        logic        busy, done, fin, dz;
        int          iters, rwait, first_seen;
        m       = model(op, a, b);
        dz      = m[32];
        exp_ctl = op[1] ? 3'b001 : 3'b000;
        exp_b   = op[1] ? b : a;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        alu_gnt = 1'b1; resp_ready = 1'b1;
        set_idle_exp();
        @(posedge clk); #1;
        req_valid = 1'b0;
        busy = !dz; done = dz; fin = 1'b0;
        iters = 0; rwait = 0; first_seen = -1;
        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            alu_gnt    = !(busy && cyc >= gs_at && cyc < gs_at + gs_len);
            resp_ready = done ? (rwait >= rs_len) : 1'b1;
            exp_busy   = busy;
            exp_valid  = done;
            exp_ready  = 1'b0;
            exp_data   = m[31:0];
            exp_dbz    = dz;
            if (resp_valid && first_seen < 0) begin
                first_seen = cyc;
                check("lit_data", resp_data, lit_data);
                check("lit_dbz", 32'(resp_dbz), 32'(lit_dbz));
            end
            @(posedge clk); #1;
            if (busy) begin
                if (alu_gnt) begin
                    iters++;
                    if (iters == 32) begin
                        busy = 1'b0;
                        done = 1'b1;
                    end
                end
            end else if (done) begin
                if (resp_ready) fin = 1'b1;
                else rwait++;
            end
        end
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL handshake: no response within 200 cycles (op %0d)", op);
        end
        check("latency", 32'(first_seen), 32'(lit_lat));
        alu_gnt = 1'b1;
        set_idle_exp();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        check({tag, "_resp_data"}, resp_data, 32'h0);
        check({tag, "_resp_dbz"}, 32'(resp_dbz), 32'h0);
        check({tag, "_alu_req"}, 32'(alu_req), 32'h0);
        check({tag, "_alu_a"}, alu_a, 32'h0);
        check({tag, "_alu_b"}, alu_b, 32'h0);
        check({tag, "_alu_ctl"}, 32'(alu_ctl), 32'h0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_a = 32'h0; req_b = 32'h0;
        resp_ready = 1'b0; alu_gnt = 1'b1;
        set_idle_exp();
        exp_ctl = 3'b000; exp_b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        chk_en = 1'b1;

        run_op(2'b00, 32'd7, 32'd6, 0, 0, 0, 33, 32'd42, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 33, 32'h0000_0001, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 33, 32'hFFFF_FFFE, 1'b0);
        run_op(2'b10, 32'd100, 32'd7, 0, 0, 0, 33, 32'd14, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 0, 0, 0, 33, 32'd2, 1'b0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 33, 32'h0000_0001, 1'b0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0, 33, 32'h7FFF_FFFF, 1'b0);
        run_op(2'b10, 32'd5, 32'd9, 0, 0, 0, 33, 32'd0, 1'b0);
        run_op(2'b11, 32'd5, 32'd9, 0, 0, 0, 33, 32'd5, 1'b0);
        run_op(2'b00, 32'd123456, 32'd789, 0, 0, 0, 33, 32'd97406784, 1'b0);
        run_op(2'b10, 32'h1234, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1'b1);
        run_op(2'b11, 32'h1234, 32'h0, 0, 0, 0, 1, 32'h0000_1234, 1'b1);
        run_op(2'b10, 32'd100, 32'd7, 10, 5, 3, 38, 32'd14, 1'b0);
        run_op(2'b01, 32'h8000_0001, 32'h0000_0003, 4, 2, 1, 35, 32'h0000_0001, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        @(posedge clk); #1;
        chk_en = 1'b0;
        req_valid = 1'b1; req_op = 2'b00; req_a = 32'h1234_5678; req_b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_alu_req", 32'(alu_req), 32'h1);
        check("mid_req_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_req_ready", 32'(req_ready), 32'h1);
        set_idle_exp();
        chk_en = 1'b1;
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 33, 32'h0000_0001, 1'b0);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
